// File: rtl/ibex_fetch_aligner.sv
// Purpose: splits a word-aligned 32-bit fetch stream into 16/32-bit RISC-V instructions with PCs and error flags.
// Latency: combinational pass-through from fetch word to instruction; one bubble after a flush to an odd halfword.
// Backpressure: fetch words are consumed only when the decoder accepts; a buffered compressed halfword blocks the fetch side.
module ibex_fetch_aligner (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,

    input  logic        flush_i,
    input  logic [31:0] flush_addr_i,

    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_pc_o,
    output logic        out_compressed_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    // HALT: waiting for a flush. ALIGNED: the instruction starts at the
    // low half of the incoming word. SKIP: discard the low half of the first
    // word after a flush. STASH: the upper half of the previous word is held.
    typedef enum logic [1:0] {
        S_HALT    = 2'd0,
        S_ALIGNED = 2'd1,
        S_SKIP    = 2'd2,
        S_STASH   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [31:0] r_pc;
    logic [15:0] r_stash;
    logic        r_stash_err;

    logic        w_word_compr;
    logic        w_stash_compr;
    logic        w_out_valid;
    logic        w_in_ready;
    logic [31:0] w_instr;
    logic        w_err;
    logic        w_err_plus2;
    logic        w_word_xfer;
    logic        w_instr_xfer;
    logic        w_instr_compr;
    logic [31:0] w_pc_inc;
    logic        w_load_stash;

    // Bit 0 of the flush target is ignored: PCs are always halfword aligned.
    logic        w_unused;
    assign w_unused = flush_addr_i[0];

    assign w_word_compr  = (in_rdata_i[1:0] != 2'b11);
    assign w_stash_compr = (r_stash[1:0] != 2'b11);

    // State register; reset wins over any flush or transfer in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= S_HALT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Output decode: what is presented to the decoder and whether a word is taken.
    always_comb begin
        w_out_valid = 1'b0;
        w_in_ready  = 1'b0;
        w_instr     = 32'h0;
        w_err       = 1'b0;
        w_err_plus2 = 1'b0;
        // A flush blocks both handshakes so nothing from the old stream leaks through.
        if (!flush_i) begin
            case (r_state)
                S_ALIGNED: begin
                    w_out_valid = in_valid_i;
                    w_in_ready  = out_ready_i;
                    w_instr     = w_word_compr ? {16'h0, in_rdata_i[15:0]} : in_rdata_i;
                    w_err       = in_err_i;
                end
                S_SKIP: begin
                    w_in_ready  = 1'b1;
                end
                S_STASH: begin
                    if (w_stash_compr) begin
                        // Self-contained compressed instruction: no new word needed.
                        w_out_valid = 1'b1;
                        w_instr     = {16'h0, r_stash};
                        w_err       = r_stash_err;
                    end else begin
                        // Instruction spans the stashed half and the new word's low half.
                        w_out_valid = in_valid_i;
                        w_in_ready  = out_ready_i;
                        w_instr     = {in_rdata_i[15:0], r_stash};
                        w_err       = r_stash_err | in_err_i;
                        w_err_plus2 = ~r_stash_err & in_err_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign w_word_xfer   = in_valid_i & w_in_ready;
    assign w_instr_xfer  = w_out_valid & out_ready_i;
    assign w_instr_compr = (w_instr[1:0] != 2'b11);
    assign w_pc_inc      = w_instr_compr ? 32'd2 : 32'd4;

    // The upper half of a consumed word is kept whenever it was not part of
    // the instruction just issued (i.e. everything except a full aligned word).
    assign w_load_stash  = w_word_xfer &
                           (((r_state == S_ALIGNED) & w_word_compr) |
                            (r_state == S_SKIP) |
                            (r_state == S_STASH));

    // Next-state logic; an accepted erroring instruction parks the block in HALT.
    always_comb begin
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = flush_addr_i[1] ? S_SKIP : S_ALIGNED;
        end else begin
            case (r_state)
                S_ALIGNED: begin
                    if (w_instr_xfer) begin
                        if (w_err) begin
                            w_next_state = S_HALT;
                        end else if (w_word_compr) begin
                            w_next_state = S_STASH;
                        end else begin
                            w_next_state = S_ALIGNED;
                        end
                    end
                end
                S_SKIP: begin
                    if (w_word_xfer) begin
                        w_next_state = S_STASH;
                    end
                end
                S_STASH: begin
                    if (w_instr_xfer) begin
                        if (w_err) begin
                            w_next_state = S_HALT;
                        end else if (w_stash_compr) begin
                            w_next_state = S_ALIGNED;
                        end else begin
                            w_next_state = S_STASH;
                        end
                    end
                end
                default: begin
                    w_next_state = S_HALT;
                end
            endcase
        end
    end

    // PC and stash registers; the PC wraps naturally modulo 2^32.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_pc        <= 32'h0;
            r_stash     <= 16'h0;
            r_stash_err <= 1'b0;
        end else if (flush_i) begin
            r_pc        <= {flush_addr_i[31:1], 1'b0};
            r_stash_err <= 1'b0;
        end else begin
            if (w_instr_xfer) begin
                r_pc <= r_pc + w_pc_inc;
            end
            if (w_load_stash) begin
                r_stash     <= in_rdata_i[31:16];
                r_stash_err <= in_err_i;
            end
        end
    end

    assign in_ready_o       = w_in_ready;
    assign out_valid_o      = w_out_valid;
    assign out_instr_o      = w_instr;
    assign out_pc_o         = r_pc;
    assign out_compressed_o = w_instr_compr;
    // Error flags only mean something alongside a valid instruction.
    assign out_err_o        = w_out_valid & w_err;
    assign out_err_plus2_o  = w_out_valid & w_err_plus2;

endmodule

// File: tb/tb_ibex_fetch_aligner.sv
// Bench for ibex_fetch_aligner: a small memory image feeds sequential fetch words,
// and every accepted instruction is compared against the instruction decoded
// directly from the memory image at the expected PC.
module tb_ibex_fetch_aligner;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] in_rdata_i = 32'h0;
    logic        in_err_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] flush_addr_i = 32'h0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;
    logic        out_compressed_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    always #5 clk_i = ~clk_i;

    ibex_fetch_aligner dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .in_valid_i       (in_valid_i),
        .in_ready_o       (in_ready_o),
        .in_rdata_i       (in_rdata_i),
        .in_err_i         (in_err_i),
        .flush_i          (flush_i),
        .flush_addr_i     (flush_addr_i),
        .out_valid_o      (out_valid_o),
        .out_ready_i      (out_ready_i),
        .out_instr_o      (out_instr_o),
        .out_pc_o         (out_pc_o),
        .out_compressed_o (out_compressed_o),
        .out_err_o        (out_err_o),
        .out_err_plus2_o  (out_err_plus2_o)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_acc = 0;

    // Memory image indexed by address bits [7:2]; aliasing makes PC wrap consistent.
    logic [31:0] mem  [64];
    logic        merr [64];

    logic [31:0] fetch_addr = 32'h0;
    logic [31:0] exp_pc     = 32'h0;
    logic        halted     = 1'b1;
    logic        pend       = 1'b0;
    logic        prev_hold  = 1'b0;
    logic [31:0] prev_instr = 32'h0;
    logic [31:0] prev_pc    = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[7:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic err_at(input logic [31:0] a);
        return merr[a[7:2]];
    endfunction

    // Reference: the instruction that starts at exp_pc in the memory image.
    task automatic model_instr(output logic [31:0] ins, output logic e, output logic p2,
                               output logic [31:0] len);
        logic [15:0] h0, h1;
        logic        e0, e1;
        h0 = half_at(exp_pc);
        e0 = err_at(exp_pc);
        if (h0[1:0] != 2'b11) begin
            ins = {16'h0, h0}; e = e0; p2 = 1'b0; len = 32'd2;
        end else begin
            h1 = half_at(exp_pc + 32'd2);
            e1 = err_at(exp_pc + 32'd2);
            ins = {h1, h0}; e = e0 | e1; p2 = e1 & ~e0; len = 32'd4;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; flush_i = 1'b1; flush_addr_i = 32'h0000_0124;
        in_valid_i = 1'b1; out_ready_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        #1;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 0);
        chk("rst_err", out_err_o, 0);
        chk("rst_err_plus2", out_err_plus2_o, 0);
        chk("rst_pc", out_pc_o, 32'h0);
        halted = 1'b1; exp_pc = 32'h0; fetch_addr = 32'h0; pend = 1'b0; prev_hold = 1'b0;
    endtask

    // One clock of stimulus plus checks; model state advances as of the next edge.
    task automatic cycle(input logic v, input logic r, input logic f, input logic [31:0] fa);
        logic [31:0] e_ins, e_len;
        logic        e_err, e_p2;
        @(negedge clk_i);
        rst_ni       = 1'b1;
        in_valid_i   = pend | v;
        out_ready_i  = r;
        flush_i      = f;
        flush_addr_i = fa;
        in_rdata_i   = mem[fetch_addr[7:2]];
        in_err_i     = merr[fetch_addr[7:2]];
        #1;
        model_instr(e_ins, e_err, e_p2, e_len);
        chk("pc", out_pc_o, exp_pc);
        if (prev_hold && !f) begin
            chk("hold_valid", out_valid_o, 1);
            chk("hold_instr", out_instr_o, prev_instr);
            chk("hold_pc", out_pc_o, prev_pc);
        end
        if (f || halted) begin
            chk("idle_out_valid", out_valid_o, 0);
            chk("idle_in_ready", in_ready_o, 0);
        end else if (out_valid_o) begin
            chk("instr", out_instr_o, e_ins);
            chk("err", out_err_o, e_err);
            chk("err_plus2", out_err_plus2_o, e_p2);
            chk("compressed", out_compressed_o, e_ins[1:0] != 2'b11);
        end
        prev_hold  = out_valid_o && !out_ready_i && !f;
        prev_instr = out_instr_o;
        prev_pc    = out_pc_o;
        if (f) begin
            halted     = 1'b0;
            exp_pc     = {fa[31:1], 1'b0};
            fetch_addr = {fa[31:2], 2'b00};
            pend       = 1'b0;
        end else begin
            pend = in_valid_i && !in_ready_o;
            if (in_valid_i && in_ready_o) fetch_addr = fetch_addr + 32'd4;
            if (out_valid_o && out_ready_i && !halted) begin
                exp_pc = exp_pc + e_len;
                n_acc++;
                if (e_err) halted = 1'b1;
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) begin
            mem[i]  = 32'h0000_0013;
            merr[i] = 1'b0;
        end
    endtask

    initial begin
        clear_mem();
        do_reset();

        // Two aligned 32-bit instructions, back to back.
        mem[0] = 32'h0000_0013; mem[1] = 32'h0010_0093;
        cycle(1, 1, 1, 32'h0000_0100);
        cycle(1, 1, 0, 0);
        chk("d20_i0", out_instr_o, 32'h0000_0013);
        chk("d20_pc0", out_pc_o, 32'h0000_0100);
        cycle(1, 1, 0, 0);
        chk("d20_i1", out_instr_o, 32'h0010_0093);
        chk("d20_pc1", out_pc_o, 32'h0000_0104);

        // Two compressed instructions packed in one word.
        mem[0] = 32'h4501_4501; mem[1] = 32'h0000_0013;
        cycle(1, 1, 1, 32'h0000_0200);
        cycle(1, 1, 0, 0);
        chk("d21_i0", out_instr_o, 32'h0000_4501);
        cycle(1, 1, 0, 0);
        chk("d21_i1", out_instr_o, 32'h0000_4501);
        chk("d21_pc1", out_pc_o, 32'h0000_0202);
        chk("d21_rdy1", in_ready_o, 0);
        cycle(1, 1, 0, 0);
        chk("d21_pc2", out_pc_o, 32'h0000_0204);

        // Reset while a halfword is stashed, then restart cleanly.
        cycle(1, 1, 1, 32'h0000_0200);
        cycle(1, 1, 0, 0);
        do_reset();
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 32'h0000_0200);
        cycle(1, 1, 0, 0);

        // Flush to an odd halfword: skip bubble then a spanning instruction.
        mem[0] = 32'h0093_1234; mem[1] = 32'hABCD_0010;
        cycle(1, 1, 1, 32'h0000_0302);
        cycle(1, 1, 0, 0);
        chk("d22_bubble", out_valid_o, 0);
        cycle(1, 1, 0, 0);
        chk("d22_instr", out_instr_o, 32'h0010_0093);
        chk("d22_pc", out_pc_o, 32'h0000_0302);
        cycle(1, 1, 0, 0);
        chk("d22_stash", out_instr_o, 32'h0000_ABCD);

        // Spanning instruction whose second word errors, then HALT.
        mem[0] = 32'h0093_0001; mem[1] = 32'h0000_0010; merr[1] = 1'b1;
        cycle(1, 1, 1, 32'h0000_0402);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        chk("d23_err", out_err_o, 1);
        chk("d23_plus2", out_err_plus2_o, 1);
        chk("d23_pc", out_pc_o, 32'h0000_0402);
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
        chk("d23_halt", out_valid_o, 0);
        clear_mem();

        // Decoder stall, flush in the middle of it.
        cycle(1, 0, 1, 32'h0000_0500);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 32'h0000_0600);
        cycle(1, 0, 0, 0);
        chk("d24_newpc", out_pc_o, 32'h0000_0600);
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);

        // PC wrap at the top of the address space.
        cycle(1, 1, 1, 32'hFFFF_FFFC);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        chk("d25_wrap", out_pc_o, 32'h0000_0000);

        // Random memory image and random handshakes, flushes and resets.
        for (int i = 0; i < 64; i++) begin
            logic [15:0] lo, hi;
            lo = 16'($urandom);
            hi = 16'($urandom);
            if ($urandom_range(0, 1) == 0) lo[1:0] = 2'b11;
            if ($urandom_range(0, 1) == 0) hi[1:0] = 2'b11;
            mem[i]  = {hi, lo};
            merr[i] = ($urandom_range(0, 15) == 0);
        end
        for (int c = 0; c < 5000; c++) begin
            logic        f;
            logic [31:0] fa;
            f  = halted ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 39) == 0);
            fa = $urandom;
            fa[0] = 1'b0;
            if ($urandom_range(0, 999) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, f, fa);
            end
        end
        chk("progress", n_acc > 500, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
